// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcodes, sequencer states and
// instruction field positions. The ALU bench reuses the opcode constants.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_NOR   = 4'b0011,
    OP_LDI   = 4'b0100,
    OP_RES5  = 4'b0101,
    OP_RES6  = 4'b0110,
    OP_RES7  = 4'b0111,
    OP_RES8  = 4'b1000,
    OP_RES9  = 4'b1001,
    OP_RES10 = 4'b1010,
    OP_SHFR  = 4'b1011,
    OP_SHFL  = 4'b1100,
    OP_RES13 = 4'b1101,
    OP_RES14 = 4'b1110,
    OP_RES15 = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // True for opcodes whose result comes from the ALU and is written back.
  function automatic logic is_alu_op(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // True for opcodes that retire as no-ops and raise illegal.
  function automatic logic is_reserved(input opcode_e op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_NOR, OP_LDI, OP_SHFL, OP_SHFR: return 1'b0;
      default:                                                  return 1'b1;
    endcase
  endfunction

  // Select value presented to the ALU; LDI and reserved codes show NOP.
  function automatic logic [3:0] alu_sel_for(input opcode_e op);
    if (is_alu_op(op)) begin
      return op;
    end else begin
      return OP_NOP;
    end
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction issue handshake between an instruction source and alu_issue_unit.
interface alu_issue_unit_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_regfile.sv
// Small register file: two operand read ports, one debug read port and one
// synchronous write port; contents cleared asynchronously on reset.
module alu_regfile #(
  parameter int NREG = 4,
  parameter int DW   = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf_r [NREG];

  // Storage with async clear and single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      rf_r[waddr] <= wdata;
    end
  end

  assign ra_data  = rf_r[ra_addr];
  assign rb_data  = rf_r[rb_addr];
  assign dbg_data = rf_r[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue sequencer feeding an external ALU_8bit (IDLE/READ/EXEC/WB).
// Optional retired-instruction counter enabled by ALU_ISSUE_PERF_CNT_EN.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_unit_if.slave issue,
  output logic [3:0]    alu_select,
  output logic [DW-1:0] alu_a_in,
  output logic [DW-1:0] alu_b_in,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry_out,
  input  logic          alu_zero_flag,
  output logic          done,
  output logic          illegal,
  output logic [DW-1:0] result,
  output logic          carry_flag,
  output logic          zero_flag,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]   retired
`endif
);

  state_e        state_r, state_s;
  logic [15:0]   instr_r;
  opcode_e       op_s;
  logic [DW-1:0] imm_s;
  logic [DW-1:0] rd_a_s, rd_b_s;
  logic [3:0]    alu_select_r;
  logic [DW-1:0] alu_a_r, alu_b_r;
  logic [DW-1:0] hold_res_r;
  logic          hold_c_r, hold_z_r;
  logic          done_r, illegal_r;
  logic [DW-1:0] result_r;
  logic          carry_r, zero_r;
  logic          we_s;
  logic [DW-1:0] wdata_s;

  assign op_s  = opcode_e'(instr_r[OPC_MSB:OPC_LSB]);
  assign imm_s = instr_r[IMM_MSB:IMM_LSB];

  alu_regfile #(.NREG(NREG), .DW(DW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we_s),
    .waddr    (instr_r[RD_MSB:RD_LSB]),
    .wdata    (wdata_s),
    .ra_addr  (instr_r[RA_MSB:RA_LSB]),
    .rb_addr  (instr_r[RB_MSB:RB_LSB]),
    .dbg_addr (dbg_addr),
    .ra_data  (rd_a_s),
    .rb_data  (rd_b_s),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: a fixed four-cycle walk once an instruction is accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue.instr_valid) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: state_s = ST_EXEC;
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Write-back port: ALU ops write the captured result, LDI writes imm.
  always_comb begin
    we_s    = 1'b0;
    wdata_s = hold_res_r;
    if (state_r == ST_WB) begin
      if (op_s == OP_LDI) begin
        we_s    = 1'b1;
        wdata_s = imm_s;
      end else if (is_alu_op(op_s)) begin
        we_s    = 1'b1;
        wdata_s = hold_res_r;
      end else begin
        we_s    = 1'b0;
        wdata_s = hold_res_r;
      end
    end else begin
      we_s    = 1'b0;
      wdata_s = hold_res_r;
    end
  end

  // Datapath registers: instruction latch, ALU drive, capture and retire state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r      <= 16'h0000;
      alu_select_r <= 4'b0000;
      alu_a_r      <= {DW{1'b0}};
      alu_b_r      <= {DW{1'b0}};
      hold_res_r   <= {DW{1'b0}};
      hold_c_r     <= 1'b0;
      hold_z_r     <= 1'b0;
      done_r       <= 1'b0;
      illegal_r    <= 1'b0;
      result_r     <= {DW{1'b0}};
      carry_r      <= 1'b0;
      zero_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue.instr_valid) begin
            instr_r <= issue.instr;
          end
        end
        ST_READ: begin
          alu_a_r      <= rd_a_s;
          alu_b_r      <= rd_b_s;
          alu_select_r <= alu_sel_for(op_s);
        end
        ST_EXEC: begin
          hold_res_r <= alu_out;
          hold_c_r   <= alu_carry_out;
          hold_z_r   <= alu_zero_flag;
          done_r     <= 1'b1;
          illegal_r  <= is_reserved(op_s);
        end
        ST_WB: begin
          done_r       <= 1'b0;
          illegal_r    <= 1'b0;
          alu_select_r <= OP_NOP;
          if (op_s == OP_LDI) begin
            result_r <= imm_s;
          end else if (is_alu_op(op_s)) begin
            result_r <= hold_res_r;
            carry_r  <= hold_c_r;
            zero_r   <= hold_z_r;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [15:0] retired_r;

  // Retired-instruction counter; every WB counts, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= 16'h0000;
    end else if (state_r == ST_WB) begin
      retired_r <= retired_r + 16'd1;
    end
  end

  assign retired = retired_r;
`endif

  assign issue.instr_ready = (state_r == ST_IDLE);
  assign alu_select        = alu_select_r;
  assign alu_a_in          = alu_a_r;
  assign alu_b_in          = alu_b_r;
  assign done              = done_r;
  assign illegal           = illegal_r;
  assign result            = result_r;
  assign carry_flag        = carry_r;
  assign zero_flag         = zero_r;

endmodule
